id_scoreboard: RTL and testbench

Parametrised register scoreboard for the decode stage. It replaces the single-EX-load stall comparison with per-register latency counters and long-latency (multi-cycle) write tracking. It sits beside the ID stage: ID presents source operands and the destination of the instruction being issued, and the scoreboard returns a combinational stall request that feeds the stall controller. It supports configurable producer latency, pipeline-hold freezing, flush, and out-of-band completion for multi-cycle units (mul/div).

---
 rtl/id_scoreboard.sv | 94 +++++++++
 tb/tb_id_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register latency counters plus
// multi-cycle (long) write tracking, producing a combinational ID stall request.
module id_scoreboard #(
  parameter  int AW   = 5,
  parameter  int CW   = 3,
  parameter  int NSRC = 2,
  localparam int NREG = 2**AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_adv,
  input  logic              flush,
  input  logic              stall_id,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic [AW-1:0]     iss_waddr,
  input  logic [CW-1:0]     iss_lat,
  input  logic              iss_long,
  input  logic [NSRC-1:0]   src_valid,
  input  logic [NSRC*AW-1:0] src_addr,
  input  logic              cpl_valid,
  input  logic [AW-1:0]     cpl_waddr,
  output logic              stallreq,
  output logic [NREG-1:0]   busy_vec,
  output logic              long_pending
);

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] lng;
  logic [NREG-1:0] busy;
  logic [AW-1:0]   sa;
  logic            src_hz;
  logic            waw_hz;
  logic            issue;

  // Counters stop at zero; a frozen or idle register never wraps back to busy.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (cnt[r] != '0) || lng[r];
    end
  end

  always_comb begin
    src_hz = 1'b0;
    sa     = '0;
    for (int i = 0; i < NSRC; i++) begin
      sa = src_addr[i*AW +: AW];
      if (src_valid[i] && (sa != '0) && busy[sa]) begin
        src_hz = 1'b1;
      end
    end
  end

  // A second write to a register with a long op in flight must wait for its completion.
  assign waw_hz   = iss_valid && iss_we && (iss_waddr != '0) && lng[iss_waddr];
  assign stallreq = src_hz || waw_hz;
  assign issue    = iss_valid && iss_we && (iss_waddr != '0) &&
                    !stallreq && !stall_id && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      lng <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (flush) begin
          cnt[r] <= '0;
        end else if (issue && (iss_waddr == AW'(r))) begin
          cnt[r] <= iss_long ? '0 : iss_lat;
        end else if (pipe_adv) begin
          cnt[r] <= sat_dec(cnt[r]);
        end
        // Issue is ordered after completion so a same-register issue wins.
        if (cpl_valid && (cpl_waddr == AW'(r))) begin
          lng[r] <= 1'b0;
        end
        if (issue && iss_long && (iss_waddr == AW'(r))) begin
          lng[r] <= 1'b1;
        end
      end
    end
  end

  assign busy_vec     = busy;
  assign long_pending = |lng;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: per-scenario tasks with an expected-value queue.
module tb_id_scoreboard;
  localparam int AW = 5;
  localparam int CW = 3;
  localparam int NSRC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_adv, flush, stall_id;
  logic              iss_valid, iss_we, iss_long;
  logic [AW-1:0]     iss_waddr;
  logic [CW-1:0]     iss_lat;
  logic [NSRC-1:0]   src_valid;
  logic [NSRC*AW-1:0] src_addr;
  logic              cpl_valid;
  logic [AW-1:0]     cpl_waddr;
  logic              stallreq;
  logic [31:0]       busy_vec;
  logic              long_pending;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  int passed = 0;
  int total  = 0;

  id_scoreboard #(.AW(AW), .CW(CW), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .pipe_adv(pipe_adv), .flush(flush), .stall_id(stall_id),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_waddr(iss_waddr), .iss_lat(iss_lat),
    .iss_long(iss_long), .src_valid(src_valid), .src_addr(src_addr),
    .cpl_valid(cpl_valid), .cpl_waddr(cpl_waddr), .stallreq(stallreq),
    .busy_vec(busy_vec), .long_pending(long_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_adv = 1'b1; flush = 1'b0; stall_id = 1'b0;
    iss_valid = 1'b0; iss_we = 1'b0; iss_waddr = '0; iss_lat = '0; iss_long = 1'b0;
    src_valid = '0; src_addr = '0; cpl_valid = 1'b0; cpl_waddr = '0;
  endtask

  task automatic drv_issue(input logic [AW-1:0] a, input logic [CW-1:0] l, input logic lg);
    iss_valid = 1'b1; iss_we = 1'b1; iss_waddr = a; iss_lat = l; iss_long = lg;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); pipe_adv = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #3;
    e = exp_q.pop_front(); total++;
    if (busy_vec !== e) $display("FAIL reset_busy: got %0h required %0h", busy_vec, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(stallreq) !== e) $display("FAIL reset_stall: got %0h required %0h", stallreq, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(long_pending) !== e) $display("FAIL reset_long: got %0h required %0h", long_pending, e); else passed++;
    tick(); tick();
    rst = 1'b1;
    tick();
    exp_q.push_back(32'd0);
    #2; e = exp_q.pop_front(); total++;
    if (busy_vec !== e) $display("FAIL idle_busy: got %0h required %0h", busy_vec, e); else passed++;
  endtask

  task automatic test_load_use();
    logic [31:0] exp_stall [5] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
    for (int c = 0; c < 5; c++) begin
      tick(); idle();
      if (c == 0) drv_issue(5'd5, 3'd1, 1'b0);
      if (c == 3) drv_issue(5'd5, 3'd0, 1'b0);
      if (c != 0) begin src_valid = 2'b01; src_addr[4:0] = 5'd5; end
      exp_q.push_back(exp_stall[c]);
      #2; e = exp_q.pop_front(); total++;
      if (32'(stallreq) !== e) $display("FAIL load_use_stall c%0d: got %0h required %0h", c, stallreq, e);
      else passed++;
    end
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); total++;
    if (32'(busy_vec[5]) !== e) $display("FAIL load_use_lat0_busy: got %0h required %0h", busy_vec[5], e);
    else passed++;
  endtask

  task automatic test_freeze();
    logic [31:0] exp_b [7] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0};
    for (int c = 0; c < 7; c++) begin
      tick(); idle();
      if (c == 0) drv_issue(5'd7, 3'd2, 1'b0);
      if (c >= 1 && c <= 3) pipe_adv = 1'b0;
      exp_q.push_back(exp_b[c]);
      #2; e = exp_q.pop_front(); total++;
      if (32'(busy_vec[7]) !== e) $display("FAIL freeze_busy7 c%0d: got %0h required %0h", c, busy_vec[7], e);
      else passed++;
    end
  endtask

  task automatic test_long_waw();
    tick(); idle(); drv_issue(5'd9, 3'd0, 1'b1);
    exp_q.push_back(32'd0);
    #2; e = exp_q.pop_front(); total++;
    if (32'(stallreq) !== e) $display("FAIL long_issue_stall: got %0h required %0h", stallreq, e); else passed++;
    for (int c = 1; c <= 3; c++) begin
      tick(); idle(); src_valid = 2'b10; src_addr[9:5] = 5'd9;
      exp_q.push_back(32'd1); exp_q.push_back(32'd1);
      #2; e = exp_q.pop_front(); total++;
      if (32'(stallreq) !== e) $display("FAIL long_src_stall c%0d: got %0h required %0h", c, stallreq, e); else passed++;
      e = exp_q.pop_front(); total++;
      if (32'(long_pending) !== e) $display("FAIL long_pending c%0d: got %0h required %0h", c, long_pending, e); else passed++;
    end
    tick(); idle(); drv_issue(5'd9, 3'd1, 1'b0);
    exp_q.push_back(32'd1);
    #2; e = exp_q.pop_front(); total++;
    if (32'(stallreq) !== e) $display("FAIL waw_stall: got %0h required %0h", stallreq, e); else passed++;
    tick(); idle(); drv_issue(5'd9, 3'd0, 1'b1);
    src_valid = 2'b10; src_addr[9:5] = 5'd9; cpl_valid = 1'b1; cpl_waddr = 5'd9;
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #2; e = exp_q.pop_front(); total++;
    if (32'(busy_vec[9]) !== e) $display("FAIL cpl_cycle_busy9: got %0h required %0h", busy_vec[9], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(stallreq) !== e) $display("FAIL cpl_cycle_stall: got %0h required %0h", stallreq, e); else passed++;
    tick(); idle(); src_valid = 2'b10; src_addr[9:5] = 5'd9;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #2; e = exp_q.pop_front(); total++;
    if (32'(stallreq) !== e) $display("FAIL after_cpl_stall: got %0h required %0h", stallreq, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(busy_vec[9]) !== e) $display("FAIL after_cpl_busy9: got %0h required %0h", busy_vec[9], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(long_pending) !== e) $display("FAIL after_cpl_long: got %0h required %0h", long_pending, e); else passed++;
  endtask

  task automatic test_flush();
    tick(); idle(); drv_issue(5'd3, 3'd3, 1'b0);
    tick(); idle(); drv_issue(5'd4, 3'd0, 1'b1);
    tick(); idle(); flush = 1'b1; drv_issue(5'd10, 3'd2, 1'b0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #2; e = exp_q.pop_front(); total++;
    if (32'(busy_vec[3]) !== e) $display("FAIL preflush_busy3: got %0h required %0h", busy_vec[3], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(busy_vec[4]) !== e) $display("FAIL preflush_busy4: got %0h required %0h", busy_vec[4], e); else passed++;
    tick(); idle(); cpl_valid = 1'b1; cpl_waddr = 5'd4;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    #2; e = exp_q.pop_front(); total++;
    if (32'(busy_vec[3]) !== e) $display("FAIL flush_busy3: got %0h required %0h", busy_vec[3], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(busy_vec[4]) !== e) $display("FAIL flush_busy4: got %0h required %0h", busy_vec[4], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(busy_vec[10]) !== e) $display("FAIL flush_issue_suppressed: got %0h required %0h", busy_vec[10], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(long_pending) !== e) $display("FAIL flush_long: got %0h required %0h", long_pending, e); else passed++;
    tick(); idle();
    exp_q.push_back(32'd0);
    #2; e = exp_q.pop_front(); total++;
    if (32'(long_pending) !== e) $display("FAIL flush_cpl_long: got %0h required %0h", long_pending, e); else passed++;
  endtask

  task automatic test_simultaneous();
    tick(); idle(); drv_issue(5'd0, 3'd3, 1'b0);
    tick(); idle(); src_valid = 2'b01; src_addr[4:0] = 5'd0;
    drv_issue(5'd6, 3'd2, 1'b0); cpl_valid = 1'b1; cpl_waddr = 5'd6;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #2; e = exp_q.pop_front(); total++;
    if (busy_vec !== e) $display("FAIL r0_busy: got %0h required %0h", busy_vec, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(stallreq) !== e) $display("FAIL r0_stall: got %0h required %0h", stallreq, e); else passed++;
    for (int c = 0; c < 3; c++) begin
      tick(); idle();
      if (c == 2) begin drv_issue(5'd8, 3'd0, 1'b1); cpl_valid = 1'b1; cpl_waddr = 5'd8; end
      exp_q.push_back((c < 2) ? 32'd1 : 32'd0);
      #2; e = exp_q.pop_front(); total++;
      if (32'(busy_vec[6]) !== e) $display("FAIL iss_cpl_busy6 c%0d: got %0h required %0h", c, busy_vec[6], e);
      else passed++;
    end
    tick(); idle(); drv_issue(5'd11, 3'd2, 1'b0); cpl_valid = 1'b1; cpl_waddr = 5'd8;
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #2; e = exp_q.pop_front(); total++;
    if (32'(busy_vec[8]) !== e) $display("FAIL same_reg_long_busy8: got %0h required %0h", busy_vec[8], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(long_pending) !== e) $display("FAIL same_reg_long_pending: got %0h required %0h", long_pending, e); else passed++;
    tick(); idle(); drv_issue(5'd9, 3'd0, 1'b1);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #2; e = exp_q.pop_front(); total++;
    if (32'(busy_vec[11]) !== e) $display("FAIL diff_reg_busy11: got %0h required %0h", busy_vec[11], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(busy_vec[8]) !== e) $display("FAIL diff_reg_busy8: got %0h required %0h", busy_vec[8], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(long_pending) !== e) $display("FAIL diff_reg_long: got %0h required %0h", long_pending, e); else passed++;
  endtask

  task automatic test_async_reset();
    tick(); idle(); src_valid = 2'b01; src_addr[4:0] = 5'd9;
    exp_q.push_back(32'd1);
    #2; e = exp_q.pop_front(); total++;
    if (32'(stallreq) !== e) $display("FAIL prereset_stall: got %0h required %0h", stallreq, e); else passed++;
    #1; rst = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1; e = exp_q.pop_front(); total++;
    if (32'(stallreq) !== e) $display("FAIL async_rst_stall: got %0h required %0h", stallreq, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (busy_vec !== e) $display("FAIL async_rst_busy: got %0h required %0h", busy_vec, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (32'(long_pending) !== e) $display("FAIL async_rst_long: got %0h required %0h", long_pending, e); else passed++;
    tick(); rst = 1'b1; idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_freeze();
    test_long_waw();
    test_flush();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
